// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit for the 5-stage RV32IM pipeline: per-register ready countdowns,
// RAW / multi-cycle MUL stalls, taken-branch flush and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter bit          FWD_EN  = 1'b0,
    parameter int unsigned WB_DIST = 3,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_D,
    input  logic              br_taken_E,
    output logic              pc_enable,
    output logic              IF_ID_enable,
    output logic              IF_ID_flush,
    output logic              ID_EX_enable,
    output logic              ID_EX_flush,
    output logic              EX_ME_enable,
    output logic              EX_ME_flush,
    output logic              ME_WB_enable,
    output logic              ME_WB_flush,
    output logic [STAT_W-1:0] stall_cycles
);

    localparam int unsigned CW_RAW = $clog2(WB_DIST + MUL_LAT + 1);
    localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int unsigned MW_RAW = $clog2(MUL_LAT);
    localparam int unsigned MW     = (MW_RAW < 1) ? 1 : MW_RAW;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0]    opcode;
    logic [6:0]    funct7;
    logic [2:0]    funct3;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          use_rs1;
    logic          use_rs2;
    logic          wr_rd;
    logic          is_load;
    logic          is_mul;
    logic [CW-1:0] r_dist;
    logic [CW-1:0] cnt_rd_dec;
    logic [CW-1:0] cnt [0:31];
    logic [MW-1:0] mul_busy;
    logic          raw_stall;
    logic          mul_stall;
    logic          issue;

    assign opcode = instr_D[6:0];
    assign rd     = instr_D[11:7];
    assign funct3 = instr_D[14:12];
    assign rs1    = instr_D[19:15];
    assign rs2    = instr_D[24:20];
    assign funct7 = instr_D[31:25];

    // Operand usage and destination write per opcode class
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr_rd   = 1'b0;
        is_load = 1'b0;
        is_mul  = 1'b0;
        case (opcode)
            OP_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                wr_rd   = 1'b1;
                is_mul  = (funct7 == 7'b0000001) && !funct3[2];
            end
            OP_IMM, OP_JALR: begin
                use_rs1 = 1'b1;
                wr_rd   = 1'b1;
            end
            OP_LOAD: begin
                use_rs1 = 1'b1;
                wr_rd   = 1'b1;
                is_load = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: wr_rd = 1'b1;
            default: ;
        endcase
    end

    // Cycles until the issued result can be consumed
    always_comb begin
        if (FWD_EN) begin
            if (is_mul)       r_dist = CW'(MUL_LAT - 1);
            else if (is_load) r_dist = CW'(1);
            else              r_dist = '0;
        end else begin
            r_dist = is_mul ? CW'(WB_DIST + MUL_LAT - 1) : CW'(WB_DIST);
        end
    end

    assign cnt_rd_dec = (cnt[rd] != '0) ? cnt[rd] - CW'(1) : '0;
    assign raw_stall  = (use_rs1 && rs1 != 5'd0 && cnt[rs1] != '0) ||
                        (use_rs2 && rs2 != 5'd0 && cnt[rs2] != '0);
    assign mul_stall  = (mul_busy != '0);
    assign issue      = !rst && !br_taken_E && !raw_stall && !mul_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
            mul_busy     <= '0;
            stall_cycles <= '0;
        end else begin
            cnt[0] <= '0;
            for (int i = 1; i < 32; i++)
                cnt[i] <= (cnt[i] != '0) ? cnt[i] - CW'(1) : '0;
            // WAW keeps whichever producer finishes later
            if (issue && wr_rd && rd != 5'd0)
                cnt[rd] <= (cnt_rd_dec > r_dist) ? cnt_rd_dec : r_dist;
            if (issue && is_mul)
                mul_busy <= MW'(MUL_LAT - 1);
            else if (mul_busy != '0)
                mul_busy <= mul_busy - MW'(1);
            if (!br_taken_E && (raw_stall || mul_stall) && stall_cycles != {STAT_W{1'b1}})
                stall_cycles <= stall_cycles + STAT_W'(1);
        end
    end

    // Pipeline register controls in priority order
    always_comb begin
        pc_enable    = 1'b1;
        IF_ID_enable = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_enable = 1'b1;
        ID_EX_flush  = 1'b0;
        EX_ME_enable = 1'b1;
        EX_ME_flush  = 1'b0;
        ME_WB_enable = 1'b1;
        ME_WB_flush  = 1'b0;
        if (rst) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            EX_ME_flush = 1'b1;
            ME_WB_flush = 1'b1;
        end else if (br_taken_E) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (mul_stall) begin
            pc_enable    = 1'b0;
            IF_ID_enable = 1'b0;
            ID_EX_enable = 1'b0;
            EX_ME_flush  = 1'b1;
        end else if (raw_stall) begin
            pc_enable    = 1'b0;
            IF_ID_enable = 1'b0;
            ID_EX_flush  = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: two instances (no forwarding / forwarding with 3-bit stall counter),
// directed decode-stage vectors with hand-computed controls and stall counts.
module tb_hazard_scoreboard;

    localparam logic [8:0] C_RUN = 9'b110101010;
    localparam logic [8:0] C_RST = 9'b111111111;
    localparam logic [8:0] C_BR  = 9'b111111010;
    localparam logic [8:0] C_RAW = 9'b000111010;
    localparam logic [8:0] C_MUL = 9'b000001110;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct {
        bit          which;
        logic [8:0]  ctrl;
        bit          chk_cnt;
        int unsigned cnt;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic        br0 = 1'b0, br1 = 1'b0;
    logic [31:0] ins0 = NOP, ins1 = NOP;

    logic pc0, ife0, iff0, ide0, idf0, exe0, exf0, mwe0, mwf0;
    logic pc1, ife1, iff1, ide1, idf1, exe1, exf1, mwe1, mwf1;
    logic [15:0] sc0;
    logic [2:0]  sc1;

    hazard_scoreboard #(.FWD_EN(1'b0), .WB_DIST(3), .MUL_LAT(4), .STAT_W(16)) dut0 (
        .clk(clk), .rst(rst0), .instr_D(ins0), .br_taken_E(br0),
        .pc_enable(pc0), .IF_ID_enable(ife0), .IF_ID_flush(iff0),
        .ID_EX_enable(ide0), .ID_EX_flush(idf0), .EX_ME_enable(exe0),
        .EX_ME_flush(exf0), .ME_WB_enable(mwe0), .ME_WB_flush(mwf0),
        .stall_cycles(sc0));

    hazard_scoreboard #(.FWD_EN(1'b1), .WB_DIST(3), .MUL_LAT(4), .STAT_W(3)) dut1 (
        .clk(clk), .rst(rst1), .instr_D(ins1), .br_taken_E(br1),
        .pc_enable(pc1), .IF_ID_enable(ife1), .IF_ID_flush(iff1),
        .ID_EX_enable(ide1), .ID_EX_flush(idf1), .EX_ME_enable(exe1),
        .EX_ME_flush(exf1), .ME_WB_enable(mwe1), .ME_WB_flush(mwf1),
        .stall_cycles(sc1));

    logic [8:0] ctrl0, ctrl1;
    assign ctrl0 = {pc0, ife0, iff0, ide0, idf0, exe0, exf0, mwe0, mwf0};
    assign ctrl1 = {pc1, ife1, iff1, ide1, idf1, exe1, exf1, mwe1, mwf1};

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'd2, rd, 7'b0000011};
    endfunction

    // Apply one decode-cycle vector and record what the monitor must see this cycle
    task automatic step(input bit d, input logic [31:0] ins, input bit br, input bit r,
                        input logic [8:0] ex, input bit cc, input int unsigned cv,
                        input string nm);
        exp_t e;
        if (d) begin ins1 = ins; br1 = br; rst1 = r; end
        else   begin ins0 = ins; br0 = br; rst0 = r; end
        e.which = d; e.ctrl = ex; e.chk_cnt = cc; e.cnt = cv; e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare at the falling edge, away from the state update
    initial begin
        exp_t e;
        logic [8:0]  act;
        int unsigned acnt;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e    = q.pop_front();
                act  = e.which ? ctrl1 : ctrl0;
                acnt = e.which ? int'(sc1) : int'(sc0);
                checks++;
                if (act !== e.ctrl) begin
                    failures++;
                    $display("FAIL %s ctrl actual=%b required=%b", e.name, act, e.ctrl);
                end
                if (e.chk_cnt) begin
                    checks++;
                    if (acnt != e.cnt) begin
                        failures++;
                        $display("FAIL %s stall_cycles actual=%0d required=%0d",
                                 e.name, acnt, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] add5, xor6, add0, add3, add11, add12, xor13, mul7, add8, sub10, add6;
        int wait_cyc;
        add5  = rtype(7'h00, 5'd2, 5'd3, 3'd0, 5'd5);
        xor6  = rtype(7'h00, 5'd1, 5'd5, 3'd4, 5'd6);
        add0  = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd0);
        add3  = rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd3);
        add11 = rtype(7'h00, 5'd1, 5'd3, 3'd0, 5'd11);
        add12 = rtype(7'h00, 5'd11, 5'd11, 3'd0, 5'd12);
        xor13 = rtype(7'h00, 5'd0, 5'd12, 3'd4, 5'd13);
        mul7  = rtype(7'h01, 5'd2, 5'd1, 3'd0, 5'd7);
        add8  = rtype(7'h00, 5'd9, 5'd9, 3'd0, 5'd8);
        sub10 = rtype(7'h20, 5'd1, 5'd7, 3'd0, 5'd10);
        add6  = rtype(7'h00, 5'd5, 5'd5, 3'd0, 5'd6);

        @(posedge clk);
        #1;
        // No forwarding: wait for writeback
        step(0, NOP,   0, 1, C_RST, 0, 0, "d0_rst_a");
        step(0, NOP,   0, 1, C_RST, 1, 0, "d0_rst_b");
        step(0, add5,  0, 0, C_RUN, 1, 0, "d0_add5");
        step(0, xor6,  0, 0, C_RAW, 1, 0, "d0_xor_st1");
        step(0, xor6,  0, 0, C_RAW, 1, 1, "d0_xor_st2");
        step(0, xor6,  0, 0, C_RAW, 1, 2, "d0_xor_st3");
        step(0, xor6,  0, 0, C_RUN, 1, 3, "d0_xor_issue");
        step(0, add0,  0, 0, C_RUN, 1, 3, "d0_add_x0");
        step(0, add3,  0, 0, C_RUN, 1, 3, "d0_read_x0");
        step(0, add11, 1, 0, C_BR,  1, 3, "d0_branch");
        step(0, add12, 0, 0, C_RUN, 1, 3, "d0_x11_free");
        step(0, xor13, 0, 0, C_RAW, 1, 3, "d0_pre_rst");
        step(0, xor13, 0, 1, C_RST, 1, 4, "d0_mid_rst");
        step(0, xor13, 0, 0, C_RUN, 1, 0, "d0_post_rst");
        step(0, mul7,  0, 0, C_RUN, 1, 0, "d0_mul");
        step(0, add8,  0, 0, C_MUL, 1, 0, "d0_mul_st1");
        step(0, add8,  0, 0, C_MUL, 1, 1, "d0_mul_st2");
        step(0, add8,  0, 0, C_MUL, 1, 2, "d0_mul_st3");
        step(0, add8,  0, 0, C_RUN, 1, 3, "d0_add8");
        step(0, sub10, 0, 0, C_RAW, 1, 3, "d0_sub_st1");
        step(0, sub10, 0, 0, C_RAW, 1, 4, "d0_sub_st2");
        step(0, sub10, 0, 0, C_RUN, 1, 5, "d0_sub_issue");

        // Forwarding, 3-bit saturating counter
        step(1, NOP,   0, 1, C_RST, 0, 0, "d1_rst_a");
        step(1, NOP,   0, 1, C_RST, 1, 0, "d1_rst_b");
        step(1, add5,  0, 0, C_RUN, 1, 0, "d1_add5");
        step(1, xor6,  0, 0, C_RUN, 1, 0, "d1_xor_fwd");
        step(1, lw(5'd5, 5'd1), 0, 0, C_RUN, 1, 0, "d1_lw");
        step(1, add6,  0, 0, C_RAW, 1, 0, "d1_loaduse");
        step(1, add6,  0, 0, C_RUN, 1, 1, "d1_loaduse_issue");
        step(1, mul7,  0, 0, C_RUN, 1, 1, "d1_mul");
        step(1, add8,  0, 0, C_MUL, 1, 1, "d1_mul_st1");
        step(1, add8,  0, 0, C_MUL, 1, 2, "d1_mul_st2");
        step(1, add8,  0, 0, C_MUL, 1, 3, "d1_mul_st3");
        step(1, add8,  0, 0, C_RUN, 1, 4, "d1_add8");
        step(1, sub10, 0, 0, C_RUN, 1, 4, "d1_sub");
        step(1, mul7,  0, 0, C_RUN, 1, 4, "d1_mul_b");
        step(1, NOP,   0, 0, C_MUL, 1, 4, "d1_mulb_st1");
        step(1, NOP,   0, 0, C_MUL, 1, 5, "d1_mulb_st2");
        step(1, NOP,   0, 0, C_MUL, 1, 6, "d1_mulb_st3");
        step(1, lw(5'd5, 5'd1), 0, 0, C_RUN, 1, 7, "d1_lw_b");
        step(1, add6,  0, 0, C_RAW, 1, 7, "d1_sat_stall");
        step(1, add6,  0, 0, C_RUN, 1, 7, "d1_saturated");

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL monitor_drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
